imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h00000000, byte address of the first instruction word written.
REQ-002 SHALL have parameter MAX_WORDS, default 256, the largest word count accepted in a header.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that restarts a load from DONE or ERROR.
REQ-006 SHALL have port in_data  input  8  incoming byte.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_write_enabled  output  1  one-cycle write strobe to the instruction memory.
REQ-010 SHALL have port mem_address  output  32  byte address for the write.
REQ-011 SHALL have port mem_data  output  32  instruction word for the write.
REQ-012 SHALL have port words_loaded  output  32  count of words written in the current load.
REQ-013 SHALL have port done  output  1  load complete; the CPU may leave reset.
REQ-014 SHALL have port error  output  1  load aborted.

Function
REQ-015 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-016 States SHALL be HEADER, PAYLOAD, CHECK (macro only), DONE and ERROR; in_ready SHALL be 1 in HEADER, PAYLOAD and CHECK, and 0 in DONE and ERROR.
REQ-017 HEADER: four accepted bytes, big-endian, SHALL form word count N.
REQ-018 After the 4th header byte: N==0 -> CHECK if the macro is defined, else DONE; N>MAX_WORDS -> ERROR with no writes; otherwise -> PAYLOAD.
REQ-019 PAYLOAD: each group of four accepted bytes, big-endian (first byte -> bits 31:24), SHALL form one instruction word.
REQ-020 In the cycle after the 4th byte of word k is accepted, mem_write_enabled SHALL be 1 for exactly one cycle, with mem_address = ADDR_BASE + 4*k (32-bit wrap) and mem_data = the word.
REQ-021 in_ready SHALL stay 1 during the write cycle; a byte accepted in that cycle SHALL belong to word k+1 and SHALL NOT corrupt the word being written.
REQ-022 words_loaded SHALL increment by 1 in the same cycle as each write strobe.
REQ-023 After the write of word N-1, the block SHALL go to CHECK if the macro is defined, else to DONE; done SHALL rise in the cycle after the final strobe, at the earliest.
REQ-024 Gaps in in_valid SHALL stall assembly without losing partial bytes.
REQ-025 DONE and ERROR SHALL be held until reset or start; start SHALL clear words_loaded, done, error and the byte/word counters, and enter HEADER on the next edge.
REQ-026 start SHALL be ignored in HEADER, PAYLOAD and CHECK.
REQ-027 done and error SHALL never be 1 simultaneously.
REQ-028 mem_address and mem_data SHALL hold their last values when mem_write_enabled is 0.

Reset
REQ-029 While reset is 0, the block SHALL asynchronously enter HEADER with in_ready=1, mem_write_enabled=0, mem_address=0, mem_data=0, words_loaded=0, done=0 and error=0.
REQ-030 Reset asserted mid-load SHALL discard partial bytes and the pending write, and a write strobe SHALL NOT be issued after release.
REQ-031 Release of reset SHALL take effect on the next rising clock edge.

Configuration
REQ-032 With IMEM_LOADER_CHECKSUM_EN defined, a running XOR of all header and payload bytes SHALL be kept, and the state SHALL be CHECK after the payload.
REQ-033 In CHECK, one accepted byte equal to the running XOR SHALL lead to DONE; any other value SHALL lead to ERROR, and already-written words are not retracted.
REQ-034 With IMEM_LOADER_CHECKSUM_EN undefined, no CHECK state and no XOR logic SHALL exist, and the flow SHALL go directly to DONE.

Verification
REQ-035 Header 00 00 00 02, then 20 08 00 05 and 01 09 50 20, in_valid held high -> two strobes: addr 0x0 data 0x20080005, then addr 0x4 data 0x01095020; words_loaded=2; done=1 (no macro).
REQ-036 Header 00 00 00 00 -> no strobe; done=1 (no macro); with macro, a following byte 0x00 -> done=1 and byte 0x01 -> error=1.
REQ-037 Header 00 00 01 01 with MAX_WORDS=256 -> error=1, in_ready=0, no strobe, further bytes ignored.
REQ-038 One-word load with in_valid toggling 1/0 every cycle -> single strobe with correct data 0xDEADBEEF at ADDR_BASE.
REQ-039 reset low after 2 of 4 payload bytes, then a fresh header 00 00 00 01 and AABBCCDD -> exactly one strobe, addr ADDR_BASE, data 0xAABBCCDD.
REQ-040 Macro defined, header 00 00 00 01, payload 11 22 33 44, checksum 0x45 -> done=1; a load with checksum 0x00 -> error=1; then start -> back in HEADER with words_loaded=0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: 4-byte big-endian word count, then N big-endian words.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_write_enabled,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic [31:0] words_loaded,
  output logic        done,
  output logic        error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_HEADER, S_PAYLOAD, S_CHECK, S_DONE, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_HEADER, S_PAYLOAD, S_DONE, S_ERROR} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] count_q, count_d;
  logic [31:0] address_d, data_d, loaded_d;
  logic        write_d, done_d, error_d, in_ready_d;
  logic        accept;
  logic [31:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  assign accept = in_valid && in_ready;
  assign word   = {shift_q, in_data};

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= S_HEADER;
      byte_cnt_q        <= 2'd0;
      shift_q           <= 24'd0;
      count_q           <= 32'd0;
      in_ready          <= 1'b1;
      mem_write_enabled <= 1'b0;
      mem_address       <= 32'd0;
      mem_data          <= 32'd0;
      words_loaded      <= 32'd0;
      done              <= 1'b0;
      error             <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q             <= 8'd0;
`endif
    end else begin
      state_q           <= state_d;
      byte_cnt_q        <= byte_cnt_d;
      shift_q           <= shift_d;
      count_q           <= count_d;
      in_ready          <= in_ready_d;
      mem_write_enabled <= write_d;
      mem_address       <= address_d;
      mem_data          <= data_d;
      words_loaded      <= loaded_d;
      done              <= done_d;
      error             <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q             <= sum_d;
`endif
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    count_d    = count_q;
    write_d    = 1'b0;
    address_d  = mem_address;
    data_d     = mem_data;
    loaded_d   = words_loaded;
    done_d     = done;
    error_d    = error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    case (state_q)
      S_HEADER: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            count_d = word;
            if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHECK;
`else
              state_d = S_DONE;
              done_d  = 1'b1;
`endif
            end else if (word > 32'(MAX_WORDS)) begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
        end
      end

      S_PAYLOAD: begin
        // The last strobe is already on the bus; finish one cycle later so done follows it.
        if (mem_write_enabled && (words_loaded == count_q)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = sum_q ^ in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            write_d   = 1'b1;
            address_d = ADDR_BASE + {words_loaded[29:0], 2'b00};
            data_d    = word;
            loaded_d  = words_loaded + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (loaded_d == count_q) state_d = S_CHECK;
`endif
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif

      S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_HEADER;
          byte_cnt_d = 2'd0;
          shift_d    = 24'd0;
          count_d    = 32'd0;
          loaded_d   = 32'd0;
          done_d     = 1'b0;
          error_d    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = 8'd0;
`endif
        end
      end

      default: state_d = S_HEADER;
    endcase

    in_ready_d = (state_d != S_DONE) && (state_d != S_ERROR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; a monitor checks every write strobe against a queue
// of expected writes built from the load format, plus end-of-load status.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
  localparam int unsigned MAXW = 256;

  logic        clock, reset, start, in_valid, in_ready;
  logic [7:0]  in_data;
  logic        mem_write_enabled, done, error;
  logic [31:0] mem_address, mem_data, words_loaded;

  imem_loader #(.ADDR_BASE(BASE), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_write_enabled(mem_write_enabled), .mem_address(mem_address),
    .mem_data(mem_data), .words_loaded(words_loaded), .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] count;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] payload[$];
  int          checks = 0;
  int          fails  = 0;
  wr_t         mon_e;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] last_data = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected-write queue
  always @(negedge clock) begin
    if (!reset) begin
      last_addr = 32'd0;
      last_data = 32'd0;
    end else begin
      if (mem_write_enabled) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe: got addr %h data %h expected no strobe", mem_address, mem_data);
        end else begin
          mon_e = exp_q.pop_front();
          check32("strobe_addr", mem_address, mon_e.addr);
          check32("strobe_data", mem_data, mon_e.data);
          check32("strobe_words_loaded", words_loaded, mon_e.count);
        end
        last_addr = mem_address;
        last_data = mem_data;
      end else begin
        check32("hold_addr", mem_address, last_addr);
        check32("hold_data", mem_data, last_data);
      end
      if (done || error) check32("done_error_exclusive", 32'(done & error), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clock);
    end
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    return 0;
  endfunction

  // Reference model: builds the byte stream and the expected writes/status from the load format
  task automatic run_load(input logic [31:0] n, input int gap_mode, input bit bad_sum);
    logic [7:0]  bytes[$];
    logic [7:0]  sum = 8'd0;
    logic [7:0]  chk;
    bit          exp_err, exp_done;
    logic [31:0] exp_loaded;
    int          guard = 0;
    for (int i = 0; i < 4; i++) bytes.push_back(8'(n >> (24 - 8 * i)));
    exp_err    = (n > 32'(MAXW));
    exp_done   = !exp_err;
    exp_loaded = exp_err ? 32'd0 : n;
    if (!exp_err) begin
      for (int k = 0; k < int'(n); k++) begin
        for (int i = 0; i < 4; i++) bytes.push_back(8'(payload[k] >> (24 - 8 * i)));
        exp_q.push_back('{BASE + 32'(k) * 32'd4, payload[k], 32'(k + 1)});
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      foreach (bytes[i]) sum = sum ^ bytes[i];
      chk = bad_sum ? (sum ^ 8'($urandom_range(1, 255))) : sum;
      bytes.push_back(chk);
      exp_done = !bad_sum;
`endif
    end
    exp_err = !exp_done;
    foreach (bytes[i]) send_byte(bytes[i], pick_gap(gap_mode));
    in_valid = 1'b0;
    while (!(done || error) && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    #1;
    check32("load_done", 32'(done), 32'(exp_done));
    check32("load_error", 32'(error), 32'(exp_err));
    check32("load_words_loaded", words_loaded, exp_loaded);
    check32("load_in_ready", 32'(in_ready), 32'd0);
    check32("load_pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check32("start_in_ready", 32'(in_ready), 32'd1);
    check32("start_done", 32'(done), 32'd0);
    check32("start_error", 32'(error), 32'd0);
    check32("start_words_loaded", words_loaded, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    #1 reset = 1'b0;
    #16;
    check32("reset_in_ready", 32'(in_ready), 32'd1);
    check32("reset_strobe", 32'(mem_write_enabled), 32'd0);
    check32("reset_addr", mem_address, 32'd0);
    check32("reset_data", mem_data, 32'd0);
    check32("reset_words_loaded", words_loaded, 32'd0);
    check32("reset_done", 32'(done), 32'd0);
    check32("reset_error", 32'(error), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Two-word load, in_valid held high
    payload = '{32'h2008_0005, 32'h0109_5020};
    run_load(32'd2, 0, 1'b0);
    do_start();

    // Empty load
    run_load(32'd0, 0, 1'b0);
    do_start();
`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load(32'd0, 0, 1'b1);
    do_start();
`endif

    // Oversized count: error, bytes ignored afterwards
    run_load(32'h0000_0101, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    @(negedge clock);
    in_valid = 1'b0;
    check32("ignored_in_ready", 32'(in_ready), 32'd0);
    check32("ignored_error", 32'(error), 32'd1);
    check32("ignored_words_loaded", words_loaded, 32'd0);
    do_start();

    // One word with in_valid toggling every cycle
    payload = '{32'hDEAD_BEEF};
    run_load(32'd1, 1, 1'b0);
    do_start();

    // Reset in the middle of a word, then a clean one-word load
    for (int i = 0; i < 4; i++) send_byte((i == 3) ? 8'h01 : 8'h00, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check32("midreset_words_loaded", words_loaded, 32'd0);
    check32("midreset_strobe", 32'(mem_write_enabled), 32'd0);
    check32("midreset_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    payload = '{32'hAABB_CCDD};
    run_load(32'd1, 0, 1'b0);
    do_start();

`ifdef IMEM_LOADER_CHECKSUM_EN
    payload = '{32'h1122_3344};
    run_load(32'd1, 0, 1'b0);
    do_start();
    run_load(32'd1, 2, 1'b1);
    do_start();
`endif

    // Largest accepted count; the address wraps past 32'hFFFFFFFC
    payload.delete();
    for (int k = 0; k < int'(MAXW); k++) payload.push_back($urandom);
    run_load(32'(MAXW), 0, 1'b0);
    do_start();

    // Random loads with random gaps
    for (int t = 0; t < 10; t++) begin
      int unsigned n;
      n = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      payload.delete();
      for (int k = 0; k < int'(n); k++) payload.push_back($urandom);
      run_load(32'(n), 2, 1'($urandom_range(0, 1)));
      do_start();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
